// File: rtl/dvp_capture_writer.sv
// ============================================================================
// dvp_capture_writer
// ----------------------------------------------------------------------------
// Camera-side writer for the asynchronous pixel FIFO that the HDMI output
// path drains. Samples the OV5640 DVP bus in the pixel-clock domain, packs
// byte pairs into RGB565 words and writes exactly H_ACTIVE x V_ACTIVE words
// per captured frame into the FIFO. The first SKIP_FRAMES complete frames
// after reset are discarded while the camera settles. Words that arrive
// while the FIFO is full are dropped and flagged. Lines or frames with the
// wrong length are flagged.
//
// Parameters:
//   H_ACTIVE           pixel words written per line
//   V_ACTIVE           lines written per frame
//   SKIP_FRAMES        complete frames discarded after reset
//   VSYNC_ACTIVE_HIGH  1: cam_vsync high means vertical blanking
//                      0: cam_vsync low means vertical blanking
//
// Ports:
//   clock          camera pixel clock (PCLK); all registers use its rising edge
//   reset          asynchronous, active-high
//   cam_vsync      camera vertical sync
//   cam_href       camera line-valid
//   cam_data[7:0]  camera byte; first byte = RGB565[15:8], second = [7:0]
//   full_fifo      FIFO full flag (write side)
//   fifo_data_out  RGB565 word to the FIFO; holds its value between writes
//   fifo_write_en  single-cycle write strobe, one per word
//   frame_start    1-cycle pulse when a captured frame begins
//   frame_done     1-cycle pulse when a captured frame ends
//   overflow       sticky: at least one word dropped because the FIFO was full
//   frame_error    sticky: a line or frame length mismatch occurred
// ============================================================================
module dvp_capture_writer #(
    parameter int H_ACTIVE          = 640,
    parameter int V_ACTIVE          = 480,
    parameter int SKIP_FRAMES       = 2,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        full_fifo,
    output logic [15:0] fifo_data_out,
    output logic        fifo_write_en,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow,
    output logic        frame_error
);

    // ------------------------------------------------------------------------
    // Counter widths. x saturates at H_ACTIVE+1 and y at V_ACTIVE+1, so both
    // counters need room for one value beyond the active size.
    // ------------------------------------------------------------------------
    localparam int XW = $clog2(H_ACTIVE + 2);
    localparam int YW = $clog2(V_ACTIVE + 2);
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SAT  = XW'(H_ACTIVE + 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE + 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP_FRAMES);
    localparam logic [SW-1:0] SKIP_ONE  = SW'(1);

    typedef enum logic [1:0] {
        ST_SKIP,
        ST_IDLE,
        ST_CAPTURE
    } state_t;

    state_t state;

    // Input stage and edge-detect history
    logic        s1_vsync;
    logic        s1_href;
    logic [7:0]  s1_data;
    logic        s2_vsync;
    logic        s2_href;
    logic [1:0]  sync_fill;

    // Capture bookkeeping
    logic [SW-1:0] skip_cnt;
    logic          phase;
    logic [7:0]    hi_byte;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Decoded events
    logic vs_blank;
    logic prev_blank;
    logic frame_begin;
    logic frame_end;
    logic href_fall;
    logic in_window;

    // ------------------------------------------------------------------------
    // Blanking level in a polarity-independent form. A falling edge of
    // vs_blank opens a frame and a rising edge closes it. Edges are only
    // trusted once both history stages hold real samples; otherwise the
    // zero reset value of the sync registers would look like a vsync
    // transition on the first cycles after reset and eat a skip frame.
    // ------------------------------------------------------------------------
    assign vs_blank    = s1_vsync ^ ~VSYNC_ACTIVE_HIGH;
    assign prev_blank  = s2_vsync ^ ~VSYNC_ACTIVE_HIGH;
    assign frame_begin = sync_fill[1] & prev_blank & ~vs_blank;
    assign frame_end   = sync_fill[1] & ~prev_blank & vs_blank;
    assign href_fall   = sync_fill[1] & s2_href & ~s1_href;
    assign in_window   = (x_cnt < X_LAST) && (y_cnt < Y_LAST);

    // ------------------------------------------------------------------------
    // Input stage: the DVP bus is registered once and every decision below
    // looks only at the registered copy. A second stage of vsync/href keeps
    // the previous sample for edge detection. sync_fill shifts in ones after
    // reset to mark when the history stages hold genuine samples.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vsync  <= 1'b0;
            s1_href   <= 1'b0;
            s1_data   <= 8'h00;
            s2_vsync  <= 1'b0;
            s2_href   <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            s1_vsync  <= cam_vsync;
            s1_href   <= cam_href;
            s1_data   <= cam_data;
            s2_vsync  <= s1_vsync;
            s2_href   <= s1_href;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // Capture state machine with registered outputs.
    //
    // SKIP counts down frame ends until the camera has settled. IDLE waits
    // for the start of the next frame. CAPTURE pairs bytes into words and
    // tracks the pixel (x) and line (y) position so only the active window
    // reaches the FIFO; anything outside it is counted but never written.
    //
    // The write strobe, the word and the frame pulses are registered, so a
    // word whose second byte is on the pins at cycle t is written at t+2.
    // The byte-pair logic still runs on the cycle of a frame end so a write
    // pending at that moment is not lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_SKIP;
            skip_cnt      <= SKIP_INIT;
            phase         <= 1'b0;
            hi_byte       <= 8'h00;
            x_cnt         <= '0;
            y_cnt         <= '0;
            fifo_data_out <= 16'h0000;
            fifo_write_en <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            fifo_write_en <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;

            case (state)
                ST_SKIP: begin
                    phase <= 1'b0;
                    if (skip_cnt == '0) begin
                        state <= ST_IDLE;
                    end else if (frame_end) begin
                        skip_cnt <= skip_cnt - SKIP_ONE;
                        if (skip_cnt == SKIP_ONE) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_IDLE: begin
                    phase <= 1'b0;
                    if (frame_begin) begin
                        state       <= ST_CAPTURE;
                        x_cnt       <= '0;
                        y_cnt       <= '0;
                        frame_start <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (s1_href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi_byte <= s1_data;
                        end else begin
                            if (in_window) begin
                                if (!full_fifo) begin
                                    fifo_write_en <= 1'b1;
                                    fifo_data_out <= {hi_byte, s1_data};
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            if (x_cnt != X_SAT) begin
                                x_cnt <= x_cnt + X_ONE;
                            end
                        end
                    end else begin
                        // Phase is forced back to the high byte between lines,
                        // which is also what discards a trailing odd byte.
                        phase <= 1'b0;
                        if (href_fall) begin
                            if (x_cnt != X_LAST) begin
                                frame_error <= 1'b1;
                            end
                            if (phase && (y_cnt < Y_LAST)) begin
                                frame_error <= 1'b1;
                            end
                            if (y_cnt != Y_SAT) begin
                                y_cnt <= y_cnt + Y_ONE;
                            end
                            x_cnt <= '0;
                        end
                    end

                    if (frame_end) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                        if (y_cnt != Y_LAST) begin
                            frame_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_SKIP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_capture_writer.sv
// ============================================================================
// tb_dvp_capture_writer
// ----------------------------------------------------------------------------
// Directed bench for dvp_capture_writer using a tiny 4x2 frame geometry.
// Two instances share the DVP href/data/full stimulus:
//   dut  : VSYNC_ACTIVE_HIGH=1, SKIP_FRAMES=1
//   dut2 : VSYNC_ACTIVE_HIGH=0, SKIP_FRAMES=0
// Each vsync is driven separately so only one instance sees a frame at a
// time; the other sits in blanking and must ignore the href activity.
// Byte b of every line carries the value b+1, so word k of a line is
// {2k+1, 2k+2}.
// ============================================================================
module tb_dvp_capture_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        vsync1;
    logic        vsync2;
    logic        href;
    logic [7:0]  data;
    logic        full;

    logic [15:0] wd1, wd2;
    logic        we1, we2;
    logic        fs1, fs2;
    logic        fd1, fd2;
    logic        ov1, ov2;
    logic        fe1, fe2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Write/pulse monitor results
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    int          t1[$];
    int          fs1c, fd1c, fs2c, fd2c;

    // Expected words built from the directed vectors
    logic [15:0] eq[$];

    // frame_error sampled a few cycles after each line ends
    int err1[4];
    int err2[4];

    dvp_capture_writer #(
        .H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(1), .VSYNC_ACTIVE_HIGH(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .cam_vsync(vsync1), .cam_href(href),
        .cam_data(data), .full_fifo(full), .fifo_data_out(wd1),
        .fifo_write_en(we1), .frame_start(fs1), .frame_done(fd1),
        .overflow(ov1), .frame_error(fe1)
    );

    dvp_capture_writer #(
        .H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(0), .VSYNC_ACTIVE_HIGH(1'b0)
    ) dut2 (
        .clock(clock), .reset(reset), .cam_vsync(vsync2), .cam_href(href),
        .cam_data(data), .full_fifo(full), .fifo_data_out(wd2),
        .fifo_write_en(we2), .frame_start(fs2), .frame_done(fd2),
        .overflow(ov2), .frame_error(fe2)
    );

    always #5 clock = ~clock;

    // Cycle counter used to measure spacing between writes
    always @(posedge clock) cyc++;

    // Record every write and count pulse cycles, sampled on the falling edge
    always @(negedge clock) begin
        if (we1) begin
            q1.push_back(wd1);
            t1.push_back(cyc);
        end
        if (we2) q2.push_back(wd2);
        if (fs1) fs1c++;
        if (fd1) fd1c++;
        if (fs2) fs2c++;
        if (fd2) fd2c++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        q1.delete();
        q2.delete();
        t1.delete();
        eq.delete();
        fs1c = 0; fd1c = 0; fs2c = 0; fd2c = 0;
    endtask

    // Append the words expected from one line; word index 'drop' is omitted
    task automatic add_line(input int nwords, input int drop);
        for (int k = 0; k < nwords; k++) begin
            if (k != drop) eq.push_back(16'(((2 * k + 1) << 8) | (2 * k + 2)));
        end
    endtask

    task automatic set_active(input int sel, input bit active);
        if (sel == 1) vsync1 = active ? 1'b0 : 1'b1;
        else          vsync2 = active ? 1'b1 : 1'b0;
    endtask

    task automatic do_reset();
        href   = 1'b0;
        full   = 1'b0;
        vsync1 = 1'b1;
        vsync2 = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    // Drive one frame to instance 'sel'. Line 0 has nb0 bytes, the rest nb.
    // full_fifo is raised so that only word full_word of line full_line sees
    // it. If reset_line >= 0, reset is asserted at byte 3 of that line, the
    // outputs of dut are checked immediately and the frame is abandoned.
    task automatic applyStimulus(input int sel, input int nlines, input int nb0,
                                 input int nb, input int full_line,
                                 input int full_word, input int reset_line);
        int n;
        for (int i = 0; i < 4; i++) begin
            err1[i] = -1;
            err2[i] = -1;
        end
        set_active(sel, 1'b1);
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            n = (l == 0) ? nb0 : nb;
            for (int b = 0; b < n; b++) begin
                if (l == reset_line && b == 3) begin
                    reset = 1'b1;
                    #1;
                    checkOutput("rst_data", int'(wd1), 0);
                    checkOutput("rst_we", int'(we1), 0);
                    checkOutput("rst_fstart", int'(fs1), 0);
                    checkOutput("rst_fdone", int'(fd1), 0);
                    checkOutput("rst_ovf", int'(ov1), 0);
                    checkOutput("rst_ferr", int'(fe1), 0);
                    href = 1'b0;
                    full = 1'b0;
                    set_active(sel, 1'b0);
                    repeat (3) tick();
                    reset = 1'b0;
                    repeat (3) tick();
                    return;
                end
                href = 1'b1;
                data = 8'(b + 1);
                full = (l == full_line) && ((b == 2 * full_word + 1) || (b == 2 * full_word + 2));
                tick();
            end
            href = 1'b0;
            full = 1'b0;
            repeat (4) tick();
            err1[l] = int'(fe1);
            err2[l] = int'(fe2);
        end
        set_active(sel, 1'b0);
        repeat (5) tick();
    endtask

    task automatic compare_writes(input int sel, input string pfx);
        if (sel == 1) begin
            checkOutput({pfx, "_wcount"}, q1.size(), eq.size());
            for (int i = 0; i < q1.size() && i < eq.size(); i++)
                checkOutput($sformatf("%s_word%0d", pfx, i), int'(q1[i]), int'(eq[i]));
        end else begin
            checkOutput({pfx, "_wcount"}, q2.size(), eq.size());
            for (int i = 0; i < q2.size() && i < eq.size(); i++)
                checkOutput($sformatf("%s_word%0d", pfx, i), int'(q2[i]), int'(eq[i]));
        end
    endtask

    initial begin
        reset  = 1'b1;
        vsync1 = 1'b1;
        vsync2 = 1'b0;
        href   = 1'b0;
        data   = 8'h00;
        full   = 1'b0;
        clear_mon();
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("reset_data", int'(wd1), 0);
        checkOutput("reset_we", int'(we1), 0);
        checkOutput("reset_fstart", int'(fs1), 0);
        checkOutput("reset_fdone", int'(fd1), 0);
        checkOutput("reset_ovf", int'(ov1), 0);
        checkOutput("reset_ferr", int'(fe1), 0);
        reset = 1'b0;
        repeat (3) tick();

        $display("[TB] skip frame then captured frame");
        clear_mon();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        checkOutput("skip_wcount", q1.size(), 0);
        checkOutput("skip_fstart", fs1c, 0);
        checkOutput("skip_fdone", fd1c, 0);
        clear_mon();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        add_line(4, -1);
        add_line(4, -1);
        compare_writes(1, "cap");
        checkOutput("cap_fstart", fs1c, 1);
        checkOutput("cap_fdone", fd1c, 1);
        checkOutput("cap_ovf", int'(ov1), 0);
        checkOutput("cap_ferr", int'(fe1), 0);
        if (t1.size() >= 2) checkOutput("cap_gap", t1[1] - t1[0], 2);
        checkOutput("dut2_idle_wcount", q2.size(), 0);

        $display("[TB] fifo full during second word");
        clear_mon();
        applyStimulus(1, 2, 8, 8, 0, 1, -1);
        add_line(4, 1);
        add_line(4, -1);
        compare_writes(1, "full");
        checkOutput("full_ovf", int'(ov1), 1);
        checkOutput("full_ferr", int'(fe1), 0);

        $display("[TB] long line of 10 bytes");
        do_reset();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        checkOutput("long_pre_ovf", int'(ov1), 0);
        checkOutput("long_pre_ferr", int'(fe1), 0);
        clear_mon();
        applyStimulus(1, 2, 10, 8, -1, 0, -1);
        add_line(4, -1);
        add_line(4, -1);
        compare_writes(1, "long");
        checkOutput("long_ferr_line0", err1[0], 1);

        $display("[TB] short odd line of 7 bytes");
        do_reset();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        checkOutput("odd7_pre_ferr", int'(fe1), 0);
        clear_mon();
        applyStimulus(1, 2, 7, 8, -1, 0, -1);
        add_line(3, -1);
        add_line(4, -1);
        compare_writes(1, "odd7");
        checkOutput("odd7_ferr_line0", err1[0], 1);

        $display("[TB] full line plus one trailing byte");
        do_reset();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        checkOutput("odd9_pre_ferr", int'(fe1), 0);
        clear_mon();
        applyStimulus(1, 2, 9, 8, -1, 0, -1);
        add_line(4, -1);
        add_line(4, -1);
        compare_writes(1, "odd9");
        checkOutput("odd9_ferr_line0", err1[0], 1);

        $display("[TB] inverted vsync, no skip, three lines");
        checkOutput("inv_pre_ferr", int'(fe2), 0);
        clear_mon();
        applyStimulus(2, 3, 8, 8, -1, 0, -1);
        add_line(4, -1);
        add_line(4, -1);
        compare_writes(2, "inv");
        checkOutput("inv_fstart", fs2c, 1);
        checkOutput("inv_fdone", fd2c, 1);
        checkOutput("inv_ferr_line1", err2[1], 0);
        checkOutput("inv_ferr_end", int'(fe2), 1);
        checkOutput("blank_href_ignored", q1.size(), 0);

        $display("[TB] reset in the middle of a captured frame");
        do_reset();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        clear_mon();
        applyStimulus(1, 2, 8, 8, -1, 0, 1);
        clear_mon();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        checkOutput("post_rst_skip_wcount", q1.size(), 0);
        checkOutput("post_rst_skip_fstart", fs1c, 0);
        clear_mon();
        applyStimulus(1, 2, 8, 8, -1, 0, -1);
        add_line(4, -1);
        add_line(4, -1);
        compare_writes(1, "post_rst");
        checkOutput("post_rst_fstart", fs1c, 1);
        checkOutput("post_rst_fdone", fd1c, 1);
        checkOutput("post_rst_ferr", int'(fe1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
